// File: rtl/bp_lce_dcache_req_responder.sv
// D$ miss/uncached request engine: issues memory commands, streams fill beats
// critical-first into the data array, writes the tag, and tracks uncached-store credits.
module bp_lce_dcache_req_responder #(
  parameter int paddr_width_p = 40,
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int block_width_p = 512,
  parameter int fill_width_p  = 64,
  parameter int credits_p     = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   cache_req_v_i,
  input  logic [1:0]                             cache_req_msg_type_i,
  input  logic [paddr_width_p-1:0]               cache_req_addr_i,
  input  logic [63:0]                            cache_req_data_i,
  output logic                                   cache_req_yumi_o,
  output logic                                   cache_req_busy_o,
  input  logic                                   cache_req_metadata_v_i,
  input  logic [$clog2(assoc_p)-1:0]             cache_req_metadata_way_i,
  output logic                                   cache_req_critical_o,
  output logic                                   cache_req_complete_o,
  output logic                                   cache_req_credits_full_o,
  output logic                                   cache_req_credits_empty_o,
  output logic                                   mem_cmd_v_o,
  input  logic                                   mem_cmd_ready_i,
  output logic [paddr_width_p-1:0]               mem_cmd_addr_o,
  output logic                                   mem_cmd_write_o,
  output logic                                   mem_cmd_uncached_o,
  output logic [63:0]                            mem_cmd_data_o,
  input  logic                                   mem_resp_v_i,
  input  logic [fill_width_p-1:0]                mem_resp_data_i,
  input  logic                                   mem_resp_store_ack_i,
  output logic                                   mem_resp_yumi_o,
  output logic                                   data_mem_pkt_v_o,
  output logic [$clog2(sets_p)-1:0]              data_mem_pkt_index_o,
  output logic [$clog2(assoc_p)-1:0]             data_mem_pkt_way_o,
  output logic [$clog2(block_width_p/fill_width_p)-1:0] data_mem_pkt_fill_index_o,
  output logic                                   data_mem_pkt_uncached_o,
  output logic [fill_width_p-1:0]                data_mem_pkt_data_o,
  input  logic                                   data_mem_pkt_yumi_i,
  output logic                                   tag_mem_pkt_v_o,
  output logic [$clog2(sets_p)-1:0]              tag_mem_pkt_index_o,
  output logic [$clog2(assoc_p)-1:0]             tag_mem_pkt_way_o,
  output logic [paddr_width_p-$clog2(block_width_p/8)-$clog2(sets_p)-1:0] tag_mem_pkt_tag_o,
  output logic [1:0]                             tag_mem_pkt_state_o,
  input  logic                                   tag_mem_pkt_yumi_i
);

  localparam int N    = block_width_p / fill_width_p;
  localparam int OFF  = $clog2(block_width_p / 8);
  localparam int IDX  = $clog2(sets_p);
  localparam int WAY  = $clog2(assoc_p);
  localparam int BEAT = $clog2(N);
  localparam int TAGW = paddr_width_p - OFF - IDX;
  localparam int FOFF = $clog2(fill_width_p / 8);
  localparam int CW   = $clog2(credits_p + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_META, S_CMD, S_FILL, S_UCRESP, S_TAG, S_DONE
  } state_e;

  state_e                   r_state, w_next;
  logic [1:0]               r_type;
  logic [paddr_width_p-1:0] r_addr;
  logic [63:0]              r_data;
  logic [WAY-1:0]           r_way;
  logic [BEAT-1:0]          r_beat;
  logic [CW-1:0]            r_cnt;

  logic w_full, w_empty, w_busy, w_req_hs, w_ack, w_dpkt_v, w_dhs;
  logic w_cmd_hs, w_inc, w_dec, w_last;
  logic [BEAT-1:0] w_crit;

  assign w_full   = (r_cnt == CW'(credits_p));
  assign w_empty  = (r_cnt == '0);
  assign w_busy   = (r_state != S_IDLE) | w_full;
  // Mealy outputs are gated so nothing handshakes while reset is held.
  assign w_req_hs = reset_n_i & cache_req_v_i & ~w_busy;
  assign w_ack    = reset_n_i & mem_resp_v_i & mem_resp_store_ack_i;
  assign w_dpkt_v = ((r_state == S_FILL) | (r_state == S_UCRESP))
                    & mem_resp_v_i & ~mem_resp_store_ack_i;
  assign w_dhs    = w_dpkt_v & data_mem_pkt_yumi_i;
  assign w_cmd_hs = (r_state == S_CMD) & mem_cmd_ready_i;
  assign w_inc    = w_cmd_hs & (r_type == 2'd3);
  assign w_dec    = w_ack & ~w_empty;
  assign w_last   = (r_beat == BEAT'(N - 1));
  assign w_crit   = r_addr[FOFF +: BEAT];

  assign cache_req_yumi_o          = w_req_hs;
  assign cache_req_busy_o          = w_busy;
  assign cache_req_critical_o      = w_dhs & ((r_state == S_UCRESP) | (r_beat == '0));
  assign cache_req_complete_o      = (r_state == S_DONE);
  assign cache_req_credits_full_o  = w_full;
  assign cache_req_credits_empty_o = w_empty;

  assign mem_cmd_v_o        = (r_state == S_CMD);
  assign mem_cmd_addr_o     = r_type[1] ? r_addr : {r_addr[paddr_width_p-1:FOFF], {FOFF{1'b0}}};
  assign mem_cmd_write_o    = (r_type == 2'd3);
  assign mem_cmd_uncached_o = r_type[1];
  assign mem_cmd_data_o     = r_data;
  assign mem_resp_yumi_o    = w_ack | w_dhs;

  assign data_mem_pkt_v_o          = w_dpkt_v;
  assign data_mem_pkt_index_o      = r_addr[OFF +: IDX];
  assign data_mem_pkt_way_o        = r_way;
  assign data_mem_pkt_fill_index_o = (r_state == S_UCRESP) ? '0 : BEAT'(w_crit + r_beat);
  assign data_mem_pkt_uncached_o   = (r_state == S_UCRESP);
  assign data_mem_pkt_data_o       = mem_resp_data_i;

  assign tag_mem_pkt_v_o     = (r_state == S_TAG);
  assign tag_mem_pkt_index_o = r_addr[OFF +: IDX];
  assign tag_mem_pkt_way_o   = r_way;
  assign tag_mem_pkt_tag_o   = r_addr[paddr_width_p-1 -: TAGW];
  assign tag_mem_pkt_state_o = (r_type == 2'd1) ? 2'b11 : 2'b01;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_req_hs) w_next = cache_req_msg_type_i[1] ? S_CMD : S_META;
      S_META:   if (cache_req_metadata_v_i) w_next = S_CMD;
      S_CMD:    if (mem_cmd_ready_i) begin
                  unique case (r_type)
                    2'd2:    w_next = S_UCRESP;
                    2'd3:    w_next = S_DONE;
                    default: w_next = S_FILL;
                  endcase
                end
      S_FILL:   if (w_dhs && w_last) w_next = S_TAG;
      S_UCRESP: if (w_dhs) w_next = S_DONE;
      S_TAG:    if (tag_mem_pkt_yumi_i) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_type  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_way   <= '0;
      r_beat  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_req_hs) begin
        r_type <= cache_req_msg_type_i;
        r_addr <= cache_req_addr_i;
        r_data <= cache_req_data_i;
        r_beat <= '0;
      end else if ((r_state == S_FILL) && w_dhs) begin
        r_beat <= r_beat + 1'b1;
      end
      if ((r_state == S_META) && cache_req_metadata_v_i) r_way <= cache_req_metadata_way_i;
      // Concurrent command and ack cancel out.
      unique case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_lce_dcache_req_responder.sv
// Directed bench for the D$ request responder: misses, uncached ops, credits, reset.
module tb_bp_lce_dcache_req_responder;
  logic clk_i = 0, reset_n_i = 0;
  logic cache_req_v_i = 0; logic [1:0] cache_req_msg_type_i = 0;
  logic [39:0] cache_req_addr_i = 0; logic [63:0] cache_req_data_i = 0;
  logic cache_req_yumi_o, cache_req_busy_o;
  logic cache_req_metadata_v_i = 0; logic [2:0] cache_req_metadata_way_i = 0;
  logic cache_req_critical_o, cache_req_complete_o, cache_req_credits_full_o, cache_req_credits_empty_o;
  logic mem_cmd_v_o, mem_cmd_ready_i = 0; logic [39:0] mem_cmd_addr_o;
  logic mem_cmd_write_o, mem_cmd_uncached_o; logic [63:0] mem_cmd_data_o;
  logic mem_resp_v_i = 0; logic [63:0] mem_resp_data_i = 0; logic mem_resp_store_ack_i = 0;
  logic mem_resp_yumi_o, data_mem_pkt_v_o; logic [5:0] data_mem_pkt_index_o;
  logic [2:0] data_mem_pkt_way_o, data_mem_pkt_fill_index_o; logic data_mem_pkt_uncached_o;
  logic [63:0] data_mem_pkt_data_o; logic data_mem_pkt_yumi_i = 0;
  logic tag_mem_pkt_v_o; logic [5:0] tag_mem_pkt_index_o; logic [2:0] tag_mem_pkt_way_o;
  logic [27:0] tag_mem_pkt_tag_o; logic [1:0] tag_mem_pkt_state_o; logic tag_mem_pkt_yumi_i = 0;

  int n_cmp = 0, n_err = 0;

  bp_lce_dcache_req_responder dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cache_req_v_i(cache_req_v_i), .cache_req_msg_type_i(cache_req_msg_type_i),
    .cache_req_addr_i(cache_req_addr_i), .cache_req_data_i(cache_req_data_i),
    .cache_req_yumi_o(cache_req_yumi_o), .cache_req_busy_o(cache_req_busy_o),
    .cache_req_metadata_v_i(cache_req_metadata_v_i), .cache_req_metadata_way_i(cache_req_metadata_way_i),
    .cache_req_critical_o(cache_req_critical_o), .cache_req_complete_o(cache_req_complete_o),
    .cache_req_credits_full_o(cache_req_credits_full_o), .cache_req_credits_empty_o(cache_req_credits_empty_o),
    .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i), .mem_cmd_addr_o(mem_cmd_addr_o),
    .mem_cmd_write_o(mem_cmd_write_o), .mem_cmd_uncached_o(mem_cmd_uncached_o), .mem_cmd_data_o(mem_cmd_data_o),
    .mem_resp_v_i(mem_resp_v_i), .mem_resp_data_i(mem_resp_data_i),
    .mem_resp_store_ack_i(mem_resp_store_ack_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .data_mem_pkt_v_o(data_mem_pkt_v_o), .data_mem_pkt_index_o(data_mem_pkt_index_o),
    .data_mem_pkt_way_o(data_mem_pkt_way_o), .data_mem_pkt_fill_index_o(data_mem_pkt_fill_index_o),
    .data_mem_pkt_uncached_o(data_mem_pkt_uncached_o), .data_mem_pkt_data_o(data_mem_pkt_data_o),
    .data_mem_pkt_yumi_i(data_mem_pkt_yumi_i),
    .tag_mem_pkt_v_o(tag_mem_pkt_v_o), .tag_mem_pkt_index_o(tag_mem_pkt_index_o),
    .tag_mem_pkt_way_o(tag_mem_pkt_way_o), .tag_mem_pkt_tag_o(tag_mem_pkt_tag_o),
    .tag_mem_pkt_state_o(tag_mem_pkt_state_o), .tag_mem_pkt_yumi_i(tag_mem_pkt_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(); @(posedge clk_i); #1; endtask

  // Stimulus only: walks a miss from request through META and CMD into FILL.
  task automatic start_miss(input logic [1:0] t, input logic [39:0] a, input logic [2:0] w);
    cache_req_v_i = 1; cache_req_msg_type_i = t; cache_req_addr_i = a; tick();
    cache_req_v_i = 0; cache_req_metadata_v_i = 1; cache_req_metadata_way_i = w; tick();
    cache_req_metadata_v_i = 0; mem_cmd_ready_i = 1; tick();
    mem_cmd_ready_i = 0;
  endtask

  task automatic uc_store(input logic [63:0] d);
    cache_req_v_i = 1; cache_req_msg_type_i = 3; cache_req_addr_i = 40'h3000; cache_req_data_i = d; tick();
    cache_req_v_i = 0; mem_cmd_ready_i = 1; tick();
    mem_cmd_ready_i = 0; tick();
  endtask

  task automatic test_reset();
    cache_req_v_i = 1; mem_resp_v_i = 1; mem_resp_store_ack_i = 1; #1;
    n_cmp++; if (cache_req_busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", cache_req_busy_o); end
    n_cmp++; if (cache_req_credits_empty_o !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b exp 1", cache_req_credits_empty_o); end
    n_cmp++; if (cache_req_yumi_o !== 1'b0) begin n_err++; $display("FAIL rst_yumi: got %b exp 0", cache_req_yumi_o); end
    n_cmp++; if (mem_resp_yumi_o !== 1'b0) begin n_err++; $display("FAIL rst_resp_yumi: got %b exp 0", mem_resp_yumi_o); end
    n_cmp++; if ({mem_cmd_v_o, data_mem_pkt_v_o, tag_mem_pkt_v_o, cache_req_complete_o, cache_req_credits_full_o} !== 5'b0) begin
      n_err++; $display("FAIL rst_valids: got %b exp 00000", {mem_cmd_v_o, data_mem_pkt_v_o, tag_mem_pkt_v_o, cache_req_complete_o, cache_req_credits_full_o}); end
    cache_req_v_i = 0; mem_resp_v_i = 0; mem_resp_store_ack_i = 0;
    tick(); reset_n_i = 1; tick();
  endtask

  task automatic test_load_miss();
    logic [2:0] efi;
    cache_req_v_i = 1; cache_req_msg_type_i = 0; cache_req_addr_i = 40'h80000028; #1;
    n_cmp++; if (cache_req_yumi_o !== 1'b1) begin n_err++; $display("FAIL ld_yumi: got %b exp 1", cache_req_yumi_o); end
    tick(); cache_req_v_i = 0; cache_req_metadata_v_i = 1; cache_req_metadata_way_i = 5; #1;
    n_cmp++; if (cache_req_busy_o !== 1'b1) begin n_err++; $display("FAIL ld_busy: got %b exp 1", cache_req_busy_o); end
    tick(); cache_req_metadata_v_i = 0; #1;
    n_cmp++; if (mem_cmd_v_o !== 1'b1) begin n_err++; $display("FAIL ld_cmd_v: got %b exp 1", mem_cmd_v_o); end
    n_cmp++; if (mem_cmd_addr_o !== 40'h80000028) begin n_err++; $display("FAIL ld_cmd_addr: got %h exp 0080000028", mem_cmd_addr_o); end
    n_cmp++; if ({mem_cmd_write_o, mem_cmd_uncached_o} !== 2'b00) begin n_err++; $display("FAIL ld_cmd_flags: got %b exp 00", {mem_cmd_write_o, mem_cmd_uncached_o}); end
    mem_cmd_ready_i = 1; tick(); mem_cmd_ready_i = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin  // store ack mid-fill: consumed, not forwarded
        mem_resp_v_i = 1; mem_resp_store_ack_i = 1; data_mem_pkt_yumi_i = 1; #1;
        n_cmp++; if (data_mem_pkt_v_o !== 1'b0) begin n_err++; $display("FAIL ack_fwd: got %b exp 0", data_mem_pkt_v_o); end
        n_cmp++; if (mem_resp_yumi_o !== 1'b1) begin n_err++; $display("FAIL ack_yumi: got %b exp 1", mem_resp_yumi_o); end
        tick(); mem_resp_store_ack_i = 0;
      end
      efi = 3'(5 + i);
      mem_resp_v_i = 1; mem_resp_data_i = 64'hA0 + 64'(i); data_mem_pkt_yumi_i = 1; #1;
      n_cmp++; if (data_mem_pkt_v_o !== 1'b1) begin n_err++; $display("FAIL ld_dv[%0d]: got %b exp 1", i, data_mem_pkt_v_o); end
      n_cmp++; if (data_mem_pkt_fill_index_o !== efi) begin n_err++; $display("FAIL ld_fi[%0d]: got %0d exp %0d", i, data_mem_pkt_fill_index_o, efi); end
      n_cmp++; if (cache_req_critical_o !== (i == 0)) begin n_err++; $display("FAIL ld_crit[%0d]: got %b exp %b", i, cache_req_critical_o, (i == 0)); end
      n_cmp++; if (data_mem_pkt_data_o !== 64'hA0 + 64'(i)) begin n_err++; $display("FAIL ld_data[%0d]: got %h", i, data_mem_pkt_data_o); end
      n_cmp++; if ({data_mem_pkt_way_o, data_mem_pkt_index_o} !== {3'd5, 6'd0}) begin n_err++; $display("FAIL ld_wayidx[%0d]: got %h exp 140", i, {data_mem_pkt_way_o, data_mem_pkt_index_o}); end
      tick();
    end
    mem_resp_v_i = 0; data_mem_pkt_yumi_i = 0; #1;
    n_cmp++; if (tag_mem_pkt_v_o !== 1'b1) begin n_err++; $display("FAIL ld_tag_v: got %b exp 1", tag_mem_pkt_v_o); end
    n_cmp++; if (tag_mem_pkt_state_o !== 2'b01) begin n_err++; $display("FAIL ld_tag_st: got %b exp 01", tag_mem_pkt_state_o); end
    n_cmp++; if (tag_mem_pkt_tag_o !== 28'h0080000) begin n_err++; $display("FAIL ld_tag: got %h exp 0080000", tag_mem_pkt_tag_o); end
    n_cmp++; if ({tag_mem_pkt_way_o, tag_mem_pkt_index_o} !== {3'd5, 6'd0}) begin n_err++; $display("FAIL ld_tag_wayidx: got %h exp 140", {tag_mem_pkt_way_o, tag_mem_pkt_index_o}); end
    tag_mem_pkt_yumi_i = 1; tick(); tag_mem_pkt_yumi_i = 0; #1;
    n_cmp++; if (cache_req_complete_o !== 1'b1) begin n_err++; $display("FAIL ld_complete: got %b exp 1", cache_req_complete_o); end
    tick();
    n_cmp++; if ({cache_req_complete_o, cache_req_busy_o} !== 2'b00) begin n_err++; $display("FAIL ld_after: got %b exp 00", {cache_req_complete_o, cache_req_busy_o}); end
  endtask

  task automatic test_store_miss_stall();
    logic [2:0] efi;
    start_miss(2'd1, 40'h1234567D, 3'd2); #1;
    n_cmp++; if (mem_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL st_cmd_done: got %b exp 0", mem_cmd_v_o); end
    for (int i = 0; i < 8; i++) begin
      efi = 3'(7 + i);
      mem_resp_v_i = 1; mem_resp_data_i = 64'hB0 + 64'(i); data_mem_pkt_yumi_i = 0;
      for (int s = 0; s < 3; s++) begin
        #1;
        n_cmp++; if ({data_mem_pkt_v_o, mem_resp_yumi_o, cache_req_critical_o} !== 3'b100) begin n_err++; $display("FAIL st_stall[%0d]: got %b exp 100", i, {data_mem_pkt_v_o, mem_resp_yumi_o, cache_req_critical_o}); end
        n_cmp++; if (data_mem_pkt_fill_index_o !== efi) begin n_err++; $display("FAIL st_stall_fi[%0d]: got %0d exp %0d", i, data_mem_pkt_fill_index_o, efi); end
        tick();
      end
      data_mem_pkt_yumi_i = 1; #1;
      n_cmp++; if (data_mem_pkt_fill_index_o !== efi) begin n_err++; $display("FAIL st_fi[%0d]: got %0d exp %0d", i, data_mem_pkt_fill_index_o, efi); end
      n_cmp++; if (cache_req_critical_o !== (i == 0)) begin n_err++; $display("FAIL st_crit[%0d]: got %b exp %b", i, cache_req_critical_o, (i == 0)); end
      n_cmp++; if (tag_mem_pkt_v_o !== 1'b0) begin n_err++; $display("FAIL st_tag_early[%0d]: got %b exp 0", i, tag_mem_pkt_v_o); end
      tick();
    end
    mem_resp_v_i = 0; data_mem_pkt_yumi_i = 0; #1;
    n_cmp++; if (tag_mem_pkt_v_o !== 1'b1) begin n_err++; $display("FAIL st_tag_v: got %b exp 1", tag_mem_pkt_v_o); end
    n_cmp++; if (tag_mem_pkt_state_o !== 2'b11) begin n_err++; $display("FAIL st_tag_st: got %b exp 11", tag_mem_pkt_state_o); end
    n_cmp++; if ({tag_mem_pkt_tag_o, tag_mem_pkt_index_o, tag_mem_pkt_way_o} !== {28'h0012345, 6'h19, 3'd2}) begin
      n_err++; $display("FAIL st_tag_fields: got %h/%h/%h exp 0012345/19/2", tag_mem_pkt_tag_o, tag_mem_pkt_index_o, tag_mem_pkt_way_o); end
    tick();  // tag packet held while yumi low
    n_cmp++; if (tag_mem_pkt_v_o !== 1'b1) begin n_err++; $display("FAIL st_tag_hold: got %b exp 1", tag_mem_pkt_v_o); end
    tag_mem_pkt_yumi_i = 1; tick(); tag_mem_pkt_yumi_i = 0; #1;
    n_cmp++; if (cache_req_complete_o !== 1'b1) begin n_err++; $display("FAIL st_complete: got %b exp 1", cache_req_complete_o); end
    tick();
  endtask

  task automatic test_miss_cmd_addr();
    cache_req_v_i = 1; cache_req_msg_type_i = 1; cache_req_addr_i = 40'h1234567D; tick();
    cache_req_v_i = 0; cache_req_metadata_v_i = 1; cache_req_metadata_way_i = 1; tick();
    cache_req_metadata_v_i = 0; #1;
    n_cmp++; if (mem_cmd_addr_o !== 40'h12345678) begin n_err++; $display("FAIL miss_cmd_addr: got %h exp 0012345678", mem_cmd_addr_o); end
    reset_n_i = 0; tick(); reset_n_i = 1; tick();
  endtask

  task automatic test_uncached_load();
    cache_req_v_i = 1; cache_req_msg_type_i = 2; cache_req_addr_i = 40'h10000004; #1;
    n_cmp++; if (cache_req_yumi_o !== 1'b1) begin n_err++; $display("FAIL ul_yumi: got %b exp 1", cache_req_yumi_o); end
    tick(); cache_req_v_i = 0; #1;
    n_cmp++; if (mem_cmd_addr_o !== 40'h10000004) begin n_err++; $display("FAIL ul_cmd_addr: got %h exp 0010000004", mem_cmd_addr_o); end
    n_cmp++; if ({mem_cmd_v_o, mem_cmd_uncached_o, mem_cmd_write_o} !== 3'b110) begin n_err++; $display("FAIL ul_cmd_flags: got %b exp 110", {mem_cmd_v_o, mem_cmd_uncached_o, mem_cmd_write_o}); end
    mem_cmd_ready_i = 1; tick(); mem_cmd_ready_i = 0;
    mem_resp_v_i = 1; mem_resp_data_i = 64'hCAFE; data_mem_pkt_yumi_i = 1; #1;
    n_cmp++; if ({data_mem_pkt_v_o, data_mem_pkt_uncached_o, cache_req_critical_o} !== 3'b111) begin n_err++; $display("FAIL ul_pkt: got %b exp 111", {data_mem_pkt_v_o, data_mem_pkt_uncached_o, cache_req_critical_o}); end
    n_cmp++; if (data_mem_pkt_fill_index_o !== 3'd0) begin n_err++; $display("FAIL ul_fi: got %0d exp 0", data_mem_pkt_fill_index_o); end
    n_cmp++; if (data_mem_pkt_data_o !== 64'hCAFE) begin n_err++; $display("FAIL ul_data: got %h exp cafe", data_mem_pkt_data_o); end
    tick(); mem_resp_v_i = 0; data_mem_pkt_yumi_i = 0; #1;
    n_cmp++; if ({cache_req_complete_o, data_mem_pkt_v_o} !== 2'b10) begin n_err++; $display("FAIL ul_complete: got %b exp 10", {cache_req_complete_o, data_mem_pkt_v_o}); end
    tick();
    n_cmp++; if (cache_req_complete_o !== 1'b0) begin n_err++; $display("FAIL ul_complete_pulse: got %b exp 0", cache_req_complete_o); end
  endtask

  task automatic test_credits();
    for (int i = 0; i < 4; i++) uc_store(64'(i));
    #1;
    n_cmp++; if ({cache_req_credits_full_o, cache_req_busy_o, cache_req_credits_empty_o} !== 3'b110) begin n_err++; $display("FAIL cr_full: got %b exp 110", {cache_req_credits_full_o, cache_req_busy_o, cache_req_credits_empty_o}); end
    cache_req_v_i = 1; cache_req_msg_type_i = 3; #1;
    n_cmp++; if (cache_req_yumi_o !== 1'b0) begin n_err++; $display("FAIL cr_full_yumi: got %b exp 0", cache_req_yumi_o); end
    cache_req_v_i = 0; mem_resp_v_i = 1; mem_resp_store_ack_i = 1; #1;
    n_cmp++; if ({mem_resp_yumi_o, data_mem_pkt_v_o} !== 2'b10) begin n_err++; $display("FAIL cr_ack: got %b exp 10", {mem_resp_yumi_o, data_mem_pkt_v_o}); end
    tick(); mem_resp_v_i = 0; mem_resp_store_ack_i = 0; #1;
    n_cmp++; if ({cache_req_credits_full_o, cache_req_busy_o} !== 2'b00) begin n_err++; $display("FAIL cr_after_ack: got %b exp 00", {cache_req_credits_full_o, cache_req_busy_o}); end
    cache_req_v_i = 1; cache_req_addr_i = 40'h2000; cache_req_data_i = 64'hDEAD_BEEF; #1;
    n_cmp++; if (cache_req_yumi_o !== 1'b1) begin n_err++; $display("FAIL cr_yumi: got %b exp 1", cache_req_yumi_o); end
    tick(); cache_req_v_i = 0; mem_cmd_ready_i = 1; mem_resp_v_i = 1; mem_resp_store_ack_i = 1; #1;
    n_cmp++; if ({mem_cmd_v_o, mem_cmd_write_o, mem_cmd_uncached_o} !== 3'b111) begin n_err++; $display("FAIL cr_cmd_flags: got %b exp 111", {mem_cmd_v_o, mem_cmd_write_o, mem_cmd_uncached_o}); end
    n_cmp++; if ({mem_cmd_addr_o, mem_cmd_data_o} !== {40'h2000, 64'hDEAD_BEEF}) begin n_err++; $display("FAIL cr_cmd_fields: got %h/%h", mem_cmd_addr_o, mem_cmd_data_o); end
    tick(); mem_cmd_ready_i = 0; mem_resp_v_i = 0; mem_resp_store_ack_i = 0; #1;
    n_cmp++; if ({cache_req_complete_o, cache_req_credits_full_o} !== 2'b10) begin n_err++; $display("FAIL cr_simul: got %b exp 10", {cache_req_complete_o, cache_req_credits_full_o}); end
    tick();
    uc_store(64'h5); #1;
    n_cmp++; if (cache_req_credits_full_o !== 1'b1) begin n_err++; $display("FAIL cr_refill: got %b exp 1", cache_req_credits_full_o); end
    mem_resp_v_i = 1; mem_resp_store_ack_i = 1; repeat (4) tick();
    mem_resp_v_i = 0; #1;
    n_cmp++; if (cache_req_credits_empty_o !== 1'b1) begin n_err++; $display("FAIL cr_drain: got %b exp 1", cache_req_credits_empty_o); end
    mem_resp_v_i = 1; #1;  // ack at zero credits
    n_cmp++; if (mem_resp_yumi_o !== 1'b1) begin n_err++; $display("FAIL cr_zero_ack_yumi: got %b exp 1", mem_resp_yumi_o); end
    tick(); mem_resp_v_i = 0; mem_resp_store_ack_i = 0; #1;
    n_cmp++; if ({cache_req_credits_empty_o, cache_req_credits_full_o} !== 2'b10) begin n_err++; $display("FAIL cr_zero_ack: got %b exp 10", {cache_req_credits_empty_o, cache_req_credits_full_o}); end
  endtask

  task automatic test_reset_mid_fill();
    start_miss(2'd0, 40'h80000028, 3'd5);
    mem_resp_v_i = 1; data_mem_pkt_yumi_i = 1;
    repeat (3) tick();
    #2; reset_n_i = 0; #1;
    n_cmp++; if ({data_mem_pkt_v_o, mem_resp_yumi_o, cache_req_critical_o, cache_req_busy_o} !== 4'b0) begin
      n_err++; $display("FAIL mr_outs: got %b exp 0000", {data_mem_pkt_v_o, mem_resp_yumi_o, cache_req_critical_o, cache_req_busy_o}); end
    tick(); mem_resp_v_i = 0; data_mem_pkt_yumi_i = 0; reset_n_i = 1; #1;
    n_cmp++; if ({cache_req_complete_o, tag_mem_pkt_v_o} !== 2'b00) begin n_err++; $display("FAIL mr_no_complete: got %b exp 00", {cache_req_complete_o, tag_mem_pkt_v_o}); end
    tick();
    n_cmp++; if (cache_req_complete_o !== 1'b0) begin n_err++; $display("FAIL mr_no_complete2: got %b exp 0", cache_req_complete_o); end
    start_miss(2'd0, 40'h80000028, 3'd5);
    mem_resp_v_i = 1; data_mem_pkt_yumi_i = 1; #1;
    n_cmp++; if (data_mem_pkt_fill_index_o !== 3'd5) begin n_err++; $display("FAIL mr_restart_fi: got %0d exp 5", data_mem_pkt_fill_index_o); end
    n_cmp++; if (cache_req_critical_o !== 1'b1) begin n_err++; $display("FAIL mr_restart_crit: got %b exp 1", cache_req_critical_o); end
    repeat (8) tick();
    mem_resp_v_i = 0; data_mem_pkt_yumi_i = 0; tag_mem_pkt_yumi_i = 1; tick();
    tag_mem_pkt_yumi_i = 0; #1;
    n_cmp++; if (cache_req_complete_o !== 1'b1) begin n_err++; $display("FAIL mr_complete: got %b exp 1", cache_req_complete_o); end
    tick();
  endtask

  initial begin
    #2;
    test_reset();
    test_load_miss();
    test_store_miss_stall();
    test_miss_cmd_addr();
    test_uncached_load();
    test_credits();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
